// File: rtl/uart_fifo_port_if.sv
// Avalon-MM slave bus and interrupt bundle for uart_fifo_port.
// The signal names match the fabric-side port names.
interface uart_fifo_port_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );
endinterface

// File: rtl/uart_fifo_port.sv
// Memory-mapped UART with TX/RX FIFOs, runtime baud divisor, sticky error flags
// and a maskable level IRQ. Register map: 0 DATA, 1 STATUS, 2 CONTROL, 3 DIVISOR.
module uart_fifo_port_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   push_ok_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             pop_ok;

  // A push into a full FIFO is only accepted when a real pop frees a slot this cycle.
  assign pop_ok    = pop_i & (count_q != '0);
  assign push_ok_o = push_i & ((count_q != (AW+1)'(DEPTH)) | pop_ok);
  assign data_o    = mem_q[rptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok_o) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)    rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok_o) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem_q[wptr_q] <= data_i;
  end
endmodule

module uart_fifo_port #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 434
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  uart_fifo_port_if.slave   avs,
  input  logic              uart_RXD,
  output logic              uart_TXD
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);

  typedef enum logic [1:0] {TXS_IDLE, TXS_START, TXS_DATA, TXS_STOP} tx_state_e;
  typedef enum logic [2:0] {RXS_IDLE, RXS_START, RXS_DATA, RXS_STOP, RXS_WAIT} rx_state_e;

  logic                 wr, rd, unused_wdata;
  logic [DIV_WIDTH-1:0] wdiv;
  logic                 tx_push_ok, tx_pop, tx_empty, tx_full, tx_idle;
  logic [DATA_BITS-1:0] tx_dout, rx_dout;
  logic [CW-1:0]        tx_count, rx_count;
  logic                 rx_push, rx_push_ok, rx_valid, ferr_set;

  logic [2:0]           ctrl_q, ctrl_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, ferr_q, ferr_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 irq_q, irq_d;

  tx_state_e            tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 txd_q, txd_d;

  logic                 rxs1_q, rxs2_q, rx_prev_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

  assign wr           = avs.avs_write;
  assign rd           = avs.avs_read & ~avs.avs_write;
  assign wdiv         = avs.avs_writedata[DIV_WIDTH-1:0];
  assign unused_wdata = ^avs.avs_writedata;

  uart_fifo_port_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_clk), .rst_i(reset_reset),
    .push_i(wr && avs.avs_address == 2'd0), .pop_i(tx_pop),
    .data_i(avs.avs_writedata[DATA_BITS-1:0]), .data_o(tx_dout),
    .push_ok_o(tx_push_ok), .count_o(tx_count)
  );

  uart_fifo_port_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_clk), .rst_i(reset_reset),
    .push_i(rx_push), .pop_i(rd && avs.avs_address == 2'd0),
    .data_i(rx_shift_q), .data_o(rx_dout),
    .push_ok_o(rx_push_ok), .count_o(rx_count)
  );

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
  assign tx_idle  = tx_empty & (tx_state_q == TXS_IDLE);
  assign rx_valid = (rx_count != '0);
  assign uart_TXD = txd_q;
  assign avs.avs_readdata = rdata_q;
  assign avs.irq  = irq_q;

  always_comb begin
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    rdata_d = '0;
    if (wr && avs.avs_address == 2'd2) ctrl_d = avs.avs_writedata[2:0];
    if (wr && avs.avs_address == 2'd3) div_d = (wdiv < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : wdiv;
    // Sticky flags: a set event in the same cycle overrides a clear.
    rx_ovf_d = (rx_ovf_q & ~(wr && avs.avs_address == 2'd1 && avs.avs_writedata[4]))
             | (rx_push & ~rx_push_ok);
    tx_ovf_d = (tx_ovf_q & ~(wr && avs.avs_address == 2'd1 && avs.avs_writedata[5]))
             | (wr && avs.avs_address == 2'd0 && !tx_push_ok);
    ferr_d   = (ferr_q & ~(wr && avs.avs_address == 2'd1 && avs.avs_writedata[6])) | ferr_set;
    if (rd) begin
      unique case (avs.avs_address)
        2'd0: if (rx_valid) begin
          rdata_d[DATA_BITS-1:0] = rx_dout;
          rdata_d[DATA_BITS]     = 1'b1;
        end
        2'd1: rdata_d = {16'(rx_count), 9'd0, ferr_q, tx_ovf_q, rx_ovf_q,
                         tx_idle, tx_empty, tx_full, rx_valid};
        2'd2: rdata_d = 32'(ctrl_q);
        default: rdata_d = 32'(div_q);
      endcase
    end
    irq_d = (ctrl_q[0] & rx_valid) | (ctrl_q[1] & tx_empty)
          | (ctrl_q[2] & (rx_ovf_q | tx_ovf_q | ferr_q));
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + DIV_WIDTH'(1);
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TXS_IDLE: tx_cnt_d = tx_cnt_q;
      TXS_START: if (tx_cnt_q == tx_div_q) begin
        tx_state_d = TXS_DATA;
        tx_cnt_d   = DIV_WIDTH'(1);
        tx_bit_d   = '0;
      end
      TXS_DATA: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d = DIV_WIDTH'(1);
        if (tx_bit_q == BW'(DATA_BITS - 1)) begin
          tx_state_d = TXS_STOP;
        end else begin
          tx_bit_d   = tx_bit_q + BW'(1);
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      default: if (tx_cnt_q == tx_div_q) tx_state_d = TXS_IDLE;
    endcase
    // Frame start from IDLE or straight out of STOP, latching the divisor here.
    if ((tx_state_q == TXS_IDLE || tx_state_d == TXS_IDLE) && !tx_empty) begin
      tx_pop     = 1'b1;
      tx_state_d = TXS_START;
      tx_cnt_d   = DIV_WIDTH'(1);
      tx_div_d   = div_q;
      tx_shift_d = tx_dout;
    end
    unique case (tx_state_d)
      TXS_START: txd_d = 1'b0;
      TXS_DATA:  txd_d = tx_shift_d[0];
      default:   txd_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + DIV_WIDTH'(1);
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    unique case (rx_state_q)
      RXS_IDLE: begin
        rx_cnt_d = DIV_WIDTH'(1);
        if (rx_prev_q && !rxs2_q) begin
          rx_state_d = RXS_START;
          rx_div_d   = div_q;
        end
      end
      RXS_START: if (rx_cnt_q == (rx_div_q >> 1)) begin
        rx_state_d = rxs2_q ? RXS_IDLE : RXS_DATA;
        rx_cnt_d   = DIV_WIDTH'(1);
        rx_bit_d   = '0;
      end
      RXS_DATA: if (rx_cnt_q == rx_div_q) begin
        rx_cnt_d   = DIV_WIDTH'(1);
        rx_shift_d = {rxs2_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == BW'(DATA_BITS - 1)) rx_state_d = RXS_STOP;
        else rx_bit_d = rx_bit_q + BW'(1);
      end
      RXS_STOP: if (rx_cnt_q == rx_div_q) begin
        rx_push    = rxs2_q;
        ferr_set   = ~rxs2_q;
        rx_state_d = rxs2_q ? RXS_IDLE : RXS_WAIT;
      end
      default: if (rxs2_q) rx_state_d = RXS_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ctrl_q     <= '0;
      div_q      <= DIV_WIDTH'(DEFAULT_DIV);
      rx_ovf_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      ferr_q     <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      tx_state_q <= TXS_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_WIDTH'(DEFAULT_DIV);
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rxs1_q     <= 1'b1;
      rxs2_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RXS_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_WIDTH'(DEFAULT_DIV);
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_ovf_q   <= tx_ovf_d;
      ferr_q     <= ferr_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rxs1_q     <= uart_RXD;
      rxs2_q     <= rxs1_q;
      rx_prev_q  <= rxs2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end
endmodule
